// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle control unit: states, opcodes, mux selects
// and the packed control-word struct passed from the decoder to the top.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXEC     = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_dec.sv
// Pure combinational state -> control-word decode. Only FETCH looks at the
// (already gated) memory-ready flag; BranchNe support is under BNE_EN.
module mc_ctrl_dec
  import mc_pkg::*;
(
  input  state_e     state,
  input  logic       mem_rdy,
`ifdef BNE_EN
  input  logic       bne_flag,
  output logic       branch_ne,
`endif
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
`ifdef BNE_EN
    branch_ne = 1'b0;
`endif
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.pc_write  = mem_rdy;
        ctrl.ir_write  = mem_rdy;
      end
      S_DECODE:  ctrl.alu_src_b = SRCB_IMMSH;
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_RTYPE_WB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
`ifdef BNE_EN
        branch_ne          = bne_flag;
`endif
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      S_ADDI_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_ADDI_WB: ctrl.reg_write = 1'b1;
      default:   ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle main control FSM: state register, opcode-driven next state,
// mem_ready gating and reset forcing. Optional bne support via BNE_EN.
module mc_ctrl_fsm
  import mc_pkg::*;
#(
  parameter bit USE_MEM_READY = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic [1:0] PCSource,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [3:0] state,
`ifdef BNE_EN
  output logic       BranchNe,
`endif
  output logic       illegal_op
);

  state_e state_q, state_d;
  logic   mem_rdy;
  logic   illegal_d;
  ctrl_t  dec_ctrl, ctrl;

  assign mem_rdy = USE_MEM_READY ? mem_ready : 1'b1;

`ifdef BNE_EN
  // Remember that the branch came from bne so BRANCH can flip the zero test.
  logic bne_q, bne_d, dec_bne;
`endif

  always_comb begin
    state_d   = state_q;
    illegal_d = 1'b0;
`ifdef BNE_EN
    bne_d     = bne_q;
`endif
    case (state_q)
      S_FETCH:  if (mem_rdy) state_d = S_DECODE;
      S_DECODE: begin
`ifdef BNE_EN
        bne_d = 1'b0;
`endif
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EX;
`ifdef BNE_EN
          OP_BNE: begin
            state_d = S_BRANCH;
            bne_d   = 1'b1;
          end
`endif
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR:   state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:    if (mem_rdy) state_d = S_MEMWB;
      S_MEMWR:    if (mem_rdy) state_d = S_FETCH;
      S_EXEC:     state_d = S_RTYPE_WB;
      S_ADDI_EX:  state_d = S_ADDI_WB;
      S_MEMWB, S_RTYPE_WB, S_BRANCH, S_JUMP, S_ADDI_WB: state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
`ifdef BNE_EN
      bne_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
`ifdef BNE_EN
      bne_q   <= bne_d;
`endif
    end
  end

  mc_ctrl_dec u_dec (
    .state     (state_q),
    .mem_rdy   (mem_rdy),
`ifdef BNE_EN
    .bne_flag  (bne_q),
    .branch_ne (dec_bne),
`endif
    .ctrl      (dec_ctrl)
  );

  // Reset forces every control low so an aborted instruction writes nothing.
  assign ctrl        = rst ? '0 : dec_ctrl;
  assign illegal_op  = ~rst & illegal_d;
`ifdef BNE_EN
  assign BranchNe    = ~rst & dec_bne;
`endif

  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign PCSource    = ctrl.pc_source;
  assign IorD        = ctrl.iord;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign IRWrite     = ctrl.ir_write;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign RegDst      = ctrl.reg_dst;
  assign RegWrite    = ctrl.reg_write;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign ALUOp       = ctrl.alu_op;
  assign state       = state_q;

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multicycle main control unit; directly upstream of the PC register, sourcing its PCWrite/PCWriteCond/PCSource.
- Moore FSM decodes the 6-bit opcode from IR and sequences fetch/decode/execute/memory/writeback.
- Drives all datapath mux selects and write enables.
- Waits on a memory-ready handshake in memory states.

Parameters:
- USE_MEM_READY, 1, when 0 the mem_ready input is ignored and treated as constant 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- opcode  in  6  IR[31:26].
- mem_ready  in  1  memory access completes this cycle.
- PCWrite  out  1  unconditional PC update.
- PCWriteCond  out  1  PC update if ALU zero.
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- IorD  out  1  memory address select, 0 PC, 1 ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  IR load.
- MemtoReg  out  1  writeback data select, 1 MDR.
- RegDst  out  1  destination register select, 1 rd.
- RegWrite  out  1  regfile write.
- ALUSrcA  out  1  ALU A select, 0 PC, 1 regA.
- ALUSrcB  out  2  ALU B select: 00 regB, 01 const 4, 10 sign-extended imm, 11 sign-extended imm<<2.
- ALUOp  out  2  00 add, 01 sub, 10 funct-decoded.
- state  out  4  current state, for debug.
- illegal_op  out  1  one-cycle pulse on unknown opcode.

Behaviour:
- Reset: state register loads FETCH(0) on a clk edge with rst=1. While rst=1, every control output is combinationally forced to 0 and PCSource=00. illegal_op is 0. rst mid-instruction aborts it with no further writes.
- States and outputs (unlisted outputs are 0):
  - FETCH(0): MemRead, ALUSrcB=01. PCWrite=IRWrite=mem_ready. Stay in FETCH until mem_ready, then DECODE.
  - DECODE(1): ALUSrcB=11. Next state by opcode:
    - lw 100011 / sw 101011 -> MEMADR
    - R 000000 -> EXEC
    - beq 000100 -> BRANCH
    - j 000010 -> JUMP
    - addi 001000 -> ADDI_EX
    - else -> FETCH, with illegal_op=1 this cycle.
  - MEMADR(2): ALUSrcA=1, ALUSrcB=10. lw -> MEMRD; sw -> MEMWR.
  - MEMRD(3): MemRead, IorD=1. Hold until mem_ready, then MEMWB.
  - MEMWB(4): MemtoReg, RegWrite -> FETCH.
  - MEMWR(5): MemWrite, IorD=1. Hold until mem_ready, then FETCH.
  - EXEC(6): ALUSrcA=1, ALUOp=10 -> RTYPE_WB.
  - RTYPE_WB(7): RegDst, RegWrite -> FETCH.
  - BRANCH(8): ALUSrcA=1, ALUOp=01, PCWriteCond, PCSource=01 -> FETCH.
  - JUMP(9): PCWrite, PCSource=10 -> FETCH.
  - ADDI_EX(10): ALUSrcA=1, ALUSrcB=10 -> ADDI_WB.
  - ADDI_WB(11): RegWrite -> FETCH.
- State codes 12-15 are unreachable; if entered, the FSM goes to FETCH with all outputs 0.
- Latency with mem_ready tied 1 (cycles from FETCH to next FETCH):
  - lw 5
  - sw, R, addi 4
  - beq, j 3
- PCWrite and PCWriteCond are never asserted together.
- opcode is sampled only in DECODE and MEMADR; IR is stable there.
- mem_ready is ignored outside FETCH/MEMRD/MEMWR.

Optional Feature:
- Macro BNE_EN.
- Defined:
  - Adds output BranchNe (1 bit).
  - bne 000101 in DECODE goes to BRANCH with BranchNe=1 during BRANCH.
  - The datapath XORs zero with BranchNe before it reaches the PC block.
- Undefined:
  - No BranchNe port.
  - 000101 is an illegal opcode.

Decomposition:
- Shared package mc_pkg holds:
  - state encodings
  - opcode constants
  - ALUOp and ALUSrcB/PCSource encodings
- One sub-module, mc_ctrl_dec: pure combinational state -> output decode. The top holds the state register, next-state logic, mem_ready gating and reset forcing.

Test Plan:
- lw, mem_ready=1: states 0,1,2,3,4,0. MemRead in 0 and 3, IorD=1 in 3, RegWrite+MemtoReg in 4, PCWrite one cycle in 0.
- FETCH with mem_ready low 3 cycles, then high: state stays 0 for 4 cycles. PCWrite/IRWrite high only in the 4th cycle.
- beq: state 8 asserts PCWriteCond=1, PCSource=01, ALUOp=01, PCWrite=0. j: state 9 asserts PCWrite=1, PCSource=10.
- opcode 111111: DECODE -> FETCH with illegal_op one cycle and no RegWrite/MemWrite.
- rst=1 asserted in MEMWR while mem_ready=0: all outputs 0 immediately, state=0 after the edge. Release rst, then one normal fetch follows.
- With BNE_EN, opcode 000101: state 8 with BranchNe=1. Without BNE_EN: illegal_op pulse.
